mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_align.sv | 47 ++++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: op/size codes, FSM states and the
// bit positions of the fields packed into EX_mem_ctrl {unsigned, size, op}.
// Latency: n/a (definitions only). Backpressure: n/a.
package mem_stage_pkg;

   // EX_mem_ctrl layout
   localparam int CTRL_W        = 5;
   localparam int CTRL_OP_LSB   = 0;
   localparam int CTRL_SIZE_LSB = 2;
   localparam int CTRL_UNS_BIT  = 4;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10
   } mem_op_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } mem_state_e;

   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte-enables/replicated write data, and load
// lane select with sign/zero extension.
// Latency: combinational. Backpressure: none.
// Ports: off_i addr[1:0]; size_i access size; uns_i zero-extend loads;
//        st_data_i store data; ld_raw_i raw memory word;
//        be_o / wdata_o to memory; ld_data_o formatted load result.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] ld_raw_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Only the address bits relevant to the access size are looked at, so a
   // misaligned half/word is naturally forced onto its aligned lanes.
   assign byte_sel = ld_raw_i[{off_i, 3'b000} +: 8];
   assign half_sel = off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];

   always_comb begin
      be_o      = 4'b1111;
      wdata_o   = st_data_i;
      ld_data_o = ld_raw_i;
      case (size_i)
         SZ_BYTE: begin
            be_o      = 4'b0001 << off_i;
            wdata_o   = {4{st_data_i[7:0]}};
            ld_data_o = uns_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be_o      = 4'b0011 << {off_i[1], 1'b0};
            wdata_o   = {2{st_data_i[15:0]}};
            ld_data_o = uns_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register plus a req/gnt/rvalid data-memory FSM.
// Latency: ALU ops pass in the cycle after capture; store 3 cycles, load 4 (zero-wait memory).
// Backpressure: MEM_busy stalls IF/ID/EX and freezes the EX/MEM register while an access is open.
// Ports: clk/rst (async active-low); EX_* from execute; MEM_* to WB and forwarding;
//        dmem_* request/grant/read-valid data-memory port.
// Optional: define MEM_MISALIGN_CHK_EN to flag misaligned half/word accesses
//           instead of force-aligning them.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       EX_alu_res,
   input  logic [31:0]       EX_mem_din,
   input  logic              EX_vld,
   input  logic [CTRL_W-1:0] EX_mem_ctrl,
   output logic [31:0]       MEM_data,
   output logic              MEM_vld,
   output logic              MEM_busy,
   output logic              MEM_misalign,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [31:0]       dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata
);

   logic [31:0]       addr_q;
   logic [31:0]       din_q;
   logic              vld_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [31:0]       ld_q;
   mem_state_e        state_q, state_d;

   logic [1:0]  op;
   logic [1:0]  size;
   logic        uns;
   logic        mem_op_vld;
   logic        misalign;
   logic        ld_en;
   logic [31:0] ld_fmt;

   // EX/MEM pipeline register: frozen while the stage is busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         din_q  <= '0;
         vld_q  <= 1'b0;
         ctrl_q <= '0;
      end else if (!MEM_busy) begin
         addr_q <= EX_alu_res;
         din_q  <= EX_mem_din;
         vld_q  <= EX_vld;
         ctrl_q <= EX_mem_ctrl;
      end
   end

   assign op   = ctrl_q[CTRL_OP_LSB +: 2];
   assign size = ctrl_q[CTRL_SIZE_LSB +: 2];
   assign uns  = ctrl_q[CTRL_UNS_BIT];

   assign mem_op_vld = vld_q && ((op == OP_LOAD) || (op == OP_STORE));

`ifdef MEM_MISALIGN_CHK_EN
   // Only meaningful in IDLE: any access that left IDLE was aligned.
   assign misalign = (state_q == ST_IDLE) && mem_op_vld && is_misaligned(size, addr_q[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign MEM_misalign = misalign;

   mem_align u_align (
      .off_i     (addr_q[1:0]),
      .size_i    (size),
      .uns_i     (uns),
      .st_data_i (din_q),
      .ld_raw_i  (dmem_rdata),
      .be_o      (dmem_be),
      .wdata_o   (dmem_wdata),
      .ld_data_o (ld_fmt)
   );

   // Request fields come straight from the frozen EX/MEM register, so they
   // stay stable for as long as the request waits for its grant.
   assign dmem_addr = {addr_q[31:2], 2'b00};
   assign dmem_we   = (op == OP_STORE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         if (ld_en) begin
            ld_q <= ld_fmt;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      MEM_busy = 1'b0;
      MEM_vld  = 1'b0;
      MEM_data = addr_q;
      dmem_req = 1'b0;
      ld_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op_vld && !misalign) begin
               MEM_busy = 1'b1;
               state_d  = ST_REQ;
            end else begin
               // ALU result (or bubble); a flagged misaligned access is dropped.
               MEM_vld = vld_q && !mem_op_vld;
            end
         end
         ST_REQ: begin
            MEM_busy = 1'b1;
            dmem_req = 1'b1;
            if (dmem_gnt) begin
               state_d = (op == OP_STORE) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            MEM_busy = 1'b1;
            if (dmem_rvalid) begin
               ld_en   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            MEM_vld  = 1'b1;
            MEM_data = (op == OP_LOAD) ? ld_q : addr_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected memory requests and
// stage results into queues; a negedge monitor pops and compares them.
// Memory responder (grant delay, read data) is modelled inside the access task.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] EX_alu_res = '0;
   logic [31:0] EX_mem_din = '0;
   logic        EX_vld = 1'b0;
   logic [4:0]  EX_mem_ctrl = '0;
   logic [31:0] MEM_data;
   logic        MEM_vld;
   logic        MEM_busy;
   logic        MEM_misalign;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        mis;
      logic [31:0] data;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   req_t er;
   rsp_t ep;
   int   checks = 0;
   int   errors = 0;

   mem_stage dut (
      .clk          (clk),
      .rst          (rst),
      .EX_alu_res   (EX_alu_res),
      .EX_mem_din   (EX_mem_din),
      .EX_vld       (EX_vld),
      .EX_mem_ctrl  (EX_mem_ctrl),
      .MEM_data     (MEM_data),
      .MEM_vld      (MEM_vld),
      .MEM_busy     (MEM_busy),
      .MEM_misalign (MEM_misalign),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata)
   );

   always #5 clk = ~clk;

   // Monitor: accepted memory requests and stage results.
   always @(negedge clk) begin
      if (rst && dmem_req && dmem_gnt) begin
         checks++;
         if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req_unexpected we=%b addr=%h be=%b wdata=%h", dmem_we, dmem_addr, dmem_be, dmem_wdata);
         end else begin
            er = req_q.pop_front();
            if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== er) begin
               errors++;
               $display("FAIL req got we=%b addr=%h be=%b wdata=%h exp we=%b addr=%h be=%b wdata=%h",
                        dmem_we, dmem_addr, dmem_be, dmem_wdata, er.we, er.addr, er.be, er.wdata);
            end
         end
      end
      if (rst && (MEM_vld || MEM_misalign)) begin
         checks++;
         if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected vld=%b mis=%b data=%h", MEM_vld, MEM_misalign, MEM_data);
         end else begin
            ep = rsp_q.pop_front();
            if (MEM_misalign !== ep.mis || MEM_vld !== ~ep.mis || (!ep.mis && MEM_data !== ep.data)) begin
               errors++;
               $display("FAIL rsp got vld=%b mis=%b data=%h exp mis=%b data=%h",
                        MEM_vld, MEM_misalign, MEM_data, ep.mis, ep.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // kind: 0 completes with MEM_vld, 1 flagged misaligned, 2 nothing expected.
   task automatic access(input string name, input logic [4:0] ctrl, input logic vld,
                         input logic [31:0] addr, input logic [31:0] din, input int gnt_dly,
                         input logic [31:0] rdata, input int kind, input req_t ereq,
                         input logic [31:0] edata, input int ebusy, input int ereqs);
      int          busy_n = 0;
      int          req_n = 0;
      bit          done = 1'b0;
      bit          rv_next = 1'b0;
      bit          moved = 1'b0;
      logic [31:0] addr0 = '0;
      if (kind == 0 && ereqs > 0) req_q.push_back(ereq);
      if (kind == 0) rsp_q.push_back({1'b0, edata});
      if (kind == 1) rsp_q.push_back({1'b1, 32'h0});
      @(posedge clk); #1;
      EX_alu_res  = addr;
      EX_mem_din  = din;
      EX_mem_ctrl = ctrl;
      EX_vld      = vld;
      @(posedge clk); #1;
      EX_vld      = 1'b0;
      EX_mem_ctrl = '0;
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         if (MEM_busy) busy_n++;
         dmem_rvalid = rv_next;
         dmem_rdata  = rv_next ? rdata : 32'hFFFF_FFFF;
         rv_next     = 1'b0;
         if (dmem_req) begin
            if (req_n == 0) addr0 = dmem_addr;
            else if (dmem_addr !== addr0) moved = 1'b1;
            req_n++;
            dmem_gnt = (req_n > gnt_dly);
            // stray read-valid while the request is still pending must be ignored
            if (!dmem_gnt) dmem_rvalid = 1'b1;
            rv_next = dmem_gnt && (ctrl[1:0] == 2'b01);
         end else begin
            dmem_gnt = 1'b0;
         end
         if (kind == 2) done = (cyc == 3);
         else done = MEM_vld || MEM_misalign;
         if (!done) begin
            @(posedge clk); #1;
         end
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout got=no_completion exp=completion", name);
      end
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(ebusy));
      check({name, "_req_cycles"}, 32'(req_n), 32'(ereqs));
      check({name, "_addr_stable"}, 32'(moved), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", 32'({MEM_vld, MEM_busy, MEM_misalign, dmem_req}), 32'd0);
      check("reset_data", MEM_data, 32'd0);
      rst = 1'b1;

      access("alu",  5'b00000, 1'b1, 32'h1234_5678, 32'h0, 0, 32'h0, 0, '0, 32'h1234_5678, 0, 0);
      access("sw",   5'b01010, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 0,
             {1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF}, 32'h0000_0100, 2, 1);
      access("lb",   5'b00001, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F, 0,
             {1'b0, 32'h100, 4'b1000, 32'h0}, 32'hFFFF_FF80, 3, 1);
      access("lbu",  5'b10001, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F, 0,
             {1'b0, 32'h100, 4'b1000, 32'h0}, 32'h0000_0080, 3, 1);
      access("lh",   5'b00101, 1'b1, 32'h0000_0102, 32'h0, 3, 32'h1234_5678, 0,
             {1'b0, 32'h100, 4'b1100, 32'h0}, 32'h0000_1234, 6, 4);
      access("sb",   5'b00010, 1'b1, 32'h0000_0101, 32'h0000_00AB, 0, 32'h0, 0,
             {1'b1, 32'h100, 4'b0010, 32'hABAB_ABAB}, 32'h0000_0101, 2, 1);
      access("sh",   5'b00110, 1'b1, 32'h0000_0102, 32'h0000_CAFE, 0, 32'h0, 0,
             {1'b1, 32'h100, 4'b1100, 32'hCAFE_CAFE}, 32'h0000_0102, 2, 1);
      access("lh_lo", 5'b00101, 1'b1, 32'h0000_0100, 32'h0, 0, 32'h0000_8001, 0,
             {1'b0, 32'h100, 4'b0011, 32'h0}, 32'hFFFF_8001, 3, 1);
`ifdef MEM_MISALIGN_CHK_EN
      access("lw_mis", 5'b01001, 1'b1, 32'h0000_0102, 32'h0, 0, 32'hA5A5_0F0F, 1, '0, 32'h0, 0, 0);
`else
      access("lw_mis", 5'b01001, 1'b1, 32'h0000_0102, 32'h0, 0, 32'hA5A5_0F0F, 0,
             {1'b0, 32'h100, 4'hF, 32'h0}, 32'hA5A5_0F0F, 3, 1);
`endif
      access("sw_novld", 5'b01010, 1'b0, 32'h0000_0300, 32'h1111_1111, 0, 32'h0, 2, '0, 32'h0, 0, 0);

      // Reset while waiting for read data; late rvalid must be ignored.
      req_q.push_back({1'b0, 32'h200, 4'hF, 32'h0});
      @(posedge clk); #1;
      EX_alu_res  = 32'h0000_0200;
      EX_mem_din  = 32'h0;
      EX_mem_ctrl = 5'b01001;
      EX_vld      = 1'b1;
      @(posedge clk); #1;
      EX_vld      = 1'b0;
      EX_mem_ctrl = '0;
      EX_alu_res  = 32'h0;
      dmem_gnt    = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      check("wait_busy", 32'(MEM_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_flags", 32'({MEM_busy, MEM_vld, dmem_req, MEM_misalign}), 32'd0);
      check("rst_async_data", MEM_data, 32'd0);
      #2 rst = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5555_AAAA;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("post_rst_vld", 32'({MEM_vld, MEM_busy, dmem_req}), 32'd0);
         check("post_rst_data", MEM_data, 32'd0);
         @(posedge clk); #1;
      end

      access("lb_after_rst", 5'b00001, 1'b1, 32'h0000_0100, 32'h0, 0, 32'h0000_007F, 0,
             {1'b0, 32'h100, 4'b0001, 32'h0}, 32'h0000_007F, 3, 1);

      repeat (2) @(posedge clk);
      #1;
      check("req_q_empty", 32'(req_q.size()), 32'd0);
      check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
